// File: rtl/fwd_pkg.sv
// Shared constants and the scoreboard entry type for the forwarding/stall controller.
// Stage indices double as forwarding-select encodings (0 = register file).
package fwd_pkg;
    localparam int STG_RF = 0;
    localparam int STG_E  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;

    localparam int RDY_D    = 0;
    localparam int RDY_ALU  = 1;
    localparam int RDY_LOAD = 2;

    localparam int RDY_W = 2;

    typedef struct packed {
        logic             valid;
        logic [4:0]       dst;
        logic [RDY_W-1:0] rdy;
    } sb_entry_t;
endpackage

// File: rtl/fwd_src_resolve.sv
// Per-operand lookup: finds the youngest in-flight writer of one source register
// and turns its position and readiness into a forwarding select or a hazard.
module fwd_src_resolve
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  sb_entry_t [DEPTH:1] i_sb,
    input  logic [4:0]          i_src_addr,
    input  logic                i_src_use,
    input  logic                i_src_en,
    output logic [SEL_W-1:0]    o_sel,
    output logic                o_hazard
);
    logic             w_hit;
    int               w_idx;
    int               w_pos;
    logic [RDY_W-1:0] w_rdy;

    always_comb begin
        w_hit    = 1'b0;
        w_idx    = 0;
        w_rdy    = '0;
        o_sel    = SEL_W'(STG_RF);
        o_hazard = 1'b0;
        // Scan oldest to youngest so the youngest match is the one that sticks.
        for (int i = DEPTH; i >= 1; i--) begin
            if (i_src_en && (i_src_addr != 5'd0) && i_sb[i].valid &&
                (i_sb[i].dst == i_src_addr)) begin
                w_hit = 1'b1;
                w_idx = i;
                w_rdy = i_sb[i].rdy;
            end
        end
        w_pos = w_idx + int'(i_src_use);
        if (w_hit) begin
            if (w_pos <= int'(w_rdy)) begin
                o_hazard = 1'b1;
            end else if (w_pos <= DEPTH) begin
                o_sel = SEL_W'(w_pos);
            end
        end
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard beside decode: forwarding selects for D and E operands,
// the decode stall, and the mult/div busy counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int MD_LATENCY = 5,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_wr,
    input  logic [4:0]               issue_dst,
    input  logic [SEL_W-1:0]         issue_rdy,
    input  logic [NUM_SRC*5-1:0]     src_addr,
    input  logic [NUM_SRC-1:0]       src_use,
    input  logic [NUM_SRC-1:0]       src_en,
    input  logic                     md_start,
    input  logic                     hilo_use_d,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_d,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_e,
    output logic                     md_busy
);
    localparam int MD_W = $clog2(MD_LATENCY + 1);

    sb_entry_t [DEPTH:1]      r_sb;
    logic [MD_W-1:0]          r_md_cnt;
    logic [NUM_SRC*SEL_W-1:0] r_fwd_sel_e;

    logic [NUM_SRC-1:0]       w_hazard;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic [NUM_SRC*SEL_W-1:0] w_sel_e_next;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_resolve #(
                .DEPTH (DEPTH),
                .SEL_W (SEL_W)
            ) u_resolve (
                .i_sb       (r_sb),
                .i_src_addr (src_addr[5*gi +: 5]),
                .i_src_use  (src_use[gi]),
                .i_src_en   (src_en[gi]),
                .o_sel      (w_sel[gi*SEL_W +: SEL_W]),
                .o_hazard   (w_hazard[gi])
            );
            // D-stage selects only matter for operands consumed in D; E ones are registered.
            assign fwd_sel_d[gi*SEL_W +: SEL_W]    = src_use[gi] ? '0 : w_sel[gi*SEL_W +: SEL_W];
            assign w_sel_e_next[gi*SEL_W +: SEL_W] = (src_use[gi] && !stall) ?
                                                     w_sel[gi*SEL_W +: SEL_W] : '0;
        end
    endgenerate

    assign md_busy   = (r_md_cnt != '0);
    assign stall     = (|w_hazard) | (hilo_use_d & (md_busy | md_start));
    assign fwd_sel_e = r_fwd_sel_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb        <= '0;
            r_md_cnt    <= '0;
            r_fwd_sel_e <= '0;
        end else begin
            // A stalled decode sends a bubble into E, so it never becomes a producer.
            r_sb[1].valid <= issue_wr & ~stall & (issue_dst != 5'd0);
            r_sb[1].dst   <= issue_dst;
            r_sb[1].rdy   <= RDY_W'(issue_rdy);
            for (int i = 2; i <= DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
            if (md_start) begin
                r_md_cnt <= MD_W'(MD_LATENCY);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - MD_W'(1);
            end
            r_fwd_sel_e <= w_sel_e_next;
        end
    end
endmodule
